// File: rtl/shift_arbiter.sv
// ---------------------------------------------------------------------------
// shift_arbiter
//
// Purpose:
//   Two requesters share one XLEN-bit shifter. Requester 0 is typically the
//   execute-stage ALU and requester 1 the load/store byte-alignment logic.
//   A round-robin arbiter grants one request per cycle through a valid/ready
//   handshake. The granted request is shifted and captured in a single result
//   register, together with the ID of the requester that owns it. The result
//   is presented one cycle after acceptance and is held until the consumer
//   takes it.
//
// Optional feature:
//   SHIFT_ARB_STATS_EN - when defined, adds saturating 16-bit grant counters
//   per requester (o_gnt0_cnt, o_gnt1_cnt). They are cleared by i_rst and are
//   not affected by i_flush.
//
// Ports:
//   i_clk                   system clock, rising edge
//   i_rst                   synchronous active-high reset
//   i_flush                 synchronous flush, drops the held result
//   i_reqN_valid            requester N has a request (N = 0, 1)
//   o_reqN_ready            requester N accepted this cycle (combinational)
//   i_reqN_a                requester N operand
//   i_reqN_shamt            requester N shift amount
//   i_reqN_type             requester N op: 00 SLL, 01 SRL, 10 SRA, 11 pass
//   o_rsp_valid             result register holds a valid result
//   i_rsp_ready             consumer takes the result this cycle
//   o_rsp_id                requester that owns o_rsp_data
//   o_rsp_data              shift result
//   o_gnt0_cnt, o_gnt1_cnt  grant counters (SHIFT_ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module shift_arbiter #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,

  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [XLEN-1:0] i_req0_a,
  input  logic [SHW-1:0]  i_req0_shamt,
  input  logic [1:0]      i_req0_type,

  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [XLEN-1:0] i_req1_a,
  input  logic [SHW-1:0]  i_req1_shamt,
  input  logic [1:0]      i_req1_type,

  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic            o_rsp_id,
  output logic [XLEN-1:0] o_rsp_data
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [15:0]     o_gnt0_cnt,
  output logic [15:0]     o_gnt1_cnt
`endif
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic            r_rsp_valid;
  logic            r_rsp_id;
  logic [XLEN-1:0] r_rsp_data;
  logic            r_ptr;        // requester favoured when both are valid

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic w_accept;
  logic w_gnt0;
  logic w_gnt1;
  logic w_any_gnt;

  // The output register can take a new result when it is empty or is being
  // drained in this same cycle. Flush and reset block any acceptance.
  assign w_accept = !i_flush && !i_rst && (!r_rsp_valid || i_rsp_ready);

  assign w_gnt0 = w_accept && i_req0_valid && (!i_req1_valid || (r_ptr == 1'b0));
  assign w_gnt1 = w_accept && i_req1_valid && (!i_req0_valid || (r_ptr == 1'b1));
  assign w_any_gnt = w_gnt0 || w_gnt1;

  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;

  // -------------------------------------------------------------------------
  // Operand selection
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] w_a;
  logic [SHW-1:0]  w_shamt;
  logic [1:0]      w_type;

  assign w_a     = w_gnt1 ? i_req1_a     : i_req0_a;
  assign w_shamt = w_gnt1 ? i_req1_shamt : i_req0_shamt;
  assign w_type  = w_gnt1 ? i_req1_type  : i_req0_type;

  // -------------------------------------------------------------------------
  // Shared logarithmic shifter
  //
  // A single right-shifting barrel serves all three ops. A left shift is a
  // right shift of the bit-reversed operand with the output reversed back.
  // The fill bit is the sign for SRA and zero otherwise.
  // -------------------------------------------------------------------------
  logic            w_left;
  logic            w_fill;
  logic [XLEN-1:0] w_in;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_result;
  logic [XLEN-1:0] w_stage [SHW+1];

  assign w_left = (w_type == 2'b00);
  assign w_fill = (w_type == 2'b10) && w_a[XLEN-1];

  generate
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_rev
      assign w_in[gi]      = w_left ? w_a[XLEN-1-gi]          : w_a[gi];
      assign w_shifted[gi] = w_left ? w_stage[SHW][XLEN-1-gi] : w_stage[SHW][gi];
    end
  endgenerate

  assign w_stage[0] = w_in;

  generate
    for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
      localparam int STEP = 1 << gi;
      assign w_stage[gi+1] = w_shamt[gi]
                           ? {{STEP{w_fill}}, w_stage[gi][XLEN-1:STEP]}
                           : w_stage[gi];
    end
  endgenerate

  // Op 11 is reserved and passes the operand through untouched.
  assign w_result = (w_type == 2'b11) ? w_a : w_shifted;

  // -------------------------------------------------------------------------
  // Result register and round-robin pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_ptr       <= 1'b0;
    end else if (i_flush) begin
      // Drop the held result; data, ID and pointer keep their values.
      r_rsp_valid <= 1'b0;
    end else if (w_any_gnt) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_gnt1;
      r_rsp_data  <= w_result;
      // Favour the requester that lost (or was idle) on the next conflict.
      r_ptr       <= w_gnt0;
    end else if (i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;

`ifdef SHIFT_ARB_STATS_EN
  // -------------------------------------------------------------------------
  // Saturating grant counters
  // -------------------------------------------------------------------------
  logic [15:0] r_gnt0_cnt;
  logic [15:0] r_gnt1_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gnt0_cnt <= '0;
      r_gnt1_cnt <= '0;
    end else begin
      if (w_gnt0 && (r_gnt0_cnt != 16'hFFFF)) begin
        r_gnt0_cnt <= r_gnt0_cnt + 16'd1;
      end
      if (w_gnt1 && (r_gnt1_cnt != 16'hFFFF)) begin
        r_gnt1_cnt <= r_gnt1_cnt + 16'd1;
      end
    end
  end

  assign o_gnt0_cnt = r_gnt0_cnt;
  assign o_gnt1_cnt = r_gnt1_cnt;
`endif

endmodule
